// File: rtl/fb_muldiv_if.sv
// fb_muldiv_if: request/response bundle between the EX stage and the
// iterative RV32M multiply/divide unit.
//   start  : request, sampled only while the unit is idle
//   md_op  : one-hot op select {mul, mulh, mulhsu, mulhu, div, divu, rem, remu}
//   op1/op2: rs1/rs2 values
//   flush  : pipeline flush, aborts the op in flight
//   busy   : op accepted and still iterating (pipeline hold)
//   done   : one-cycle pulse, result valid
//   result : op result, held until the next accepted start
interface fb_muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [7:0]      md_op;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, md_op, op1, op2, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, md_op, op1, op2, flush,
      output busy, done, result
   );
endinterface

// File: rtl/fb_muldiv.sv
// fb_muldiv: iterative RV32M multiply/divide unit.
// One shared 64-bit accumulator performs either a shift-add multiply or a
// restoring divide on operand magnitudes, one radix-2 step per cycle, and
// the sign is fixed up at the end.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : fb_muldiv_if slave (start/md_op/op1/op2/flush in, busy/done/result out)
module fb_muldiv #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   fb_muldiv_if.slave    bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   localparam int              CW   = $clog2(ITER);
   localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

   state_t            state_q, state_d;
   op_t               op_q, op_d;
   logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {rem, quotient}
   logic [XLEN-1:0]   m_q, m_d;         // multiplicand or divisor magnitude
   logic              neg_q, neg_d;     // negate the final value
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Request decode: highest set md_op bit wins.
   op_t             op_sel;
   logic            sel_div, s1, s2, neg1, neg2, div_zero, div_ovf;
   logic [XLEN-1:0] mag1, mag2;

   always_comb begin
      op_sel = OP_MUL;
      if      (bus.md_op[7]) op_sel = OP_MUL;
      else if (bus.md_op[6]) op_sel = OP_MULH;
      else if (bus.md_op[5]) op_sel = OP_MULHSU;
      else if (bus.md_op[4]) op_sel = OP_MULHU;
      else if (bus.md_op[3]) op_sel = OP_DIV;
      else if (bus.md_op[2]) op_sel = OP_DIVU;
      else if (bus.md_op[1]) op_sel = OP_REM;
      else                   op_sel = OP_REMU;

      sel_div  = op_sel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      s1       = op_sel inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      s2       = op_sel inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      neg1     = s1 & bus.op1[XLEN-1];
      neg2     = s2 & bus.op2[XLEN-1];
      mag1     = neg1 ? -bus.op1 : bus.op1;
      mag2     = neg2 ? -bus.op2 : bus.op2;
      div_zero = (bus.op2 == '0);
      div_ovf  = (op_sel inside {OP_DIV, OP_REM}) && (bus.op1 == MIN) && (bus.op2 == ONES);
   end

   // One radix-2 step of each algorithm.
   logic [XLEN:0]     mul_sum, div_cand;
   logic [XLEN-1:0]   div_diff, div_rem;
   logic              div_ge, is_mul_q;
   logic [2*XLEN-1:0] mul_next, div_next;

   always_comb begin
      is_mul_q = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? m_q : {XLEN{1'b0}})};
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      // Shift in the next dividend bit; the partial remainder stays below
      // the divisor, so the 33-bit candidate is always under 2*divisor.
      div_cand = acc_q[2*XLEN-1:XLEN-1];
      div_ge   = (div_cand >= {1'b0, m_q});
      div_diff = div_cand[XLEN-1:0] - m_q;
      div_rem  = div_ge ? div_diff : div_cand[XLEN-1:0];
      div_next = {div_rem, acc_q[XLEN-2:0], div_ge};
   end

   // Sign correction and result selection from the finished accumulator.
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fin_val;

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       fin_val = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fin_val = quo_fix;
         default:                      fin_val = rem_fix;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      m_d      = m_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (!bus.flush && bus.start && (bus.md_op != 8'h00)) begin
               op_d  = op_sel;
               cnt_d = '0;
               if (sel_div && div_zero) begin
                  // Preload the architectural answer and skip CALC.
                  acc_d   = {bus.op1, ONES};
                  m_d     = '0;
                  neg_d   = 1'b0;
                  state_d = S_FIN;
               end else if (div_ovf) begin
                  acc_d   = {{XLEN{1'b0}}, MIN};
                  m_d     = '0;
                  neg_d   = 1'b0;
                  state_d = S_FIN;
               end else if (!sel_div) begin
                  acc_d   = {{XLEN{1'b0}}, mag2};
                  m_d     = mag1;
                  neg_d   = neg1 ^ neg2;
                  state_d = S_CALC;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, mag1};
                  m_d     = mag2;
                  // Remainder follows the dividend; quotient the XOR.
                  neg_d   = (op_sel inside {OP_REM, OP_REMU}) ? neg1 : (neg1 ^ neg2);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = is_mul_q ? mul_next : div_next;
               if (cnt_q == CW'(ITER - 1)) state_d = S_FIN;
               else                        cnt_d   = cnt_q + 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            if (!bus.flush) result_d = fin_val;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_MUL;
         acc_q    <= '0;
         m_q      <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         m_q      <= m_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // The result is presented combinationally in the FIN cycle so it lines up
   // with done; a flush in that cycle suppresses both.
   assign bus.busy   = (state_q == S_CALC);
   assign bus.done   = (state_q == S_FIN) && !bus.flush;
   assign bus.result = bus.done ? fin_val : result_q;

endmodule
